// File: rtl/servant_uart_rx.sv
// Oversampling 8N1 UART receiver for the servant console line.
// Decodes LSB-first frames and presents each byte on a valid/ready handshake.
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic             rx_p0;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             vld_p1;

  // Stage 0: two-flop synchronizer, idles high
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_s  <= rx_p0;
    end
  end

  // Stage 1: frame FSM; vld_p1 marks a good stop bit, shreg holds the byte
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      vld_p1      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      vld_p1      <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            // A start bit that is high again by mid-bit was a glitch
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              vld_p1 <= 1'b1;
              state  <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          // Holding here until the line rises turns a break into a single error
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 2: output register with valid/ready handshake and overrun detection
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (vld_p1) begin
        if (!o_valid || i_ready) begin
          o_data  <= shreg;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx at 16 clocks per bit.
// A timeline model built from the driven frames is compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_servant_uart_rx;

  localparam int CPB    = 16;
  localparam int HALF   = CPB / 2;
  localparam int T_STOP = 2 + HALF + 9 * CPB;   // edge offset of the stop-bit sample
  localparam int T_DLV  = T_STOP + 1;           // edge offset where o_valid rises
  localparam int NCYC   = 8000;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       i_rx     = 1'b1;
  logic       i_ready  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  servant_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 wb_clk = ~wb_clk;

  int         edge_n = 0;
  bit         rdy_s  = 1'b0;
  bit         rst_s  = 1'b0;
  int         exp_dlv  [NCYC];
  bit         exp_ferr [NCYC];
  bit         exp_busy [NCYC];
  int         vec_n = 0;
  int         err_n = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovr   = 1'b0;
  logic       prev_valid = 1'b0;
  int         rise_t[$];
  int         rise_d[$];
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vec_n++;
    if (act !== want) begin
      err_n++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, want);
    end
  endtask

  always @(posedge wb_clk) begin
    edge_n++;
    rdy_s = i_ready;
    rst_s = wb_rst_n;
  end

  always @(negedge wb_clk) begin
    if (edge_n > 0 && edge_n < NCYC) begin
      if (!rst_s) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
      end else begin
        m_ovr = 1'b0;
        if (exp_dlv[edge_n] >= 0) begin
          if (!m_valid || rdy_s) begin
            m_valid = 1'b1;
            m_data  = exp_dlv[edge_n][7:0];
          end else begin
            m_ovr = 1'b1;
          end
        end else if (m_valid && rdy_s) begin
          m_valid = 1'b0;
        end
      end
      chk("valid",     32'(o_valid),     32'(m_valid));
      chk("data",      32'(o_data),      32'(m_data));
      chk("overrun",   32'(o_overrun),   32'(m_ovr));
      chk("frame_err", 32'(o_frame_err), 32'(rst_s & exp_ferr[edge_n]));
      chk("busy",      32'(o_busy),      32'(rst_s & exp_busy[edge_n]));
      if (o_valid === 1'b1 && prev_valid !== 1'b1) begin
        rise_t.push_back(edge_n);
        rise_d.push_back(int'(o_data));
      end
      prev_valid = o_valid;
      if (o_frame_err === 1'b1) ferr_cnt++;
      if (o_overrun === 1'b1) ovr_cnt++;
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, output int t0);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    t0 = edge_n + 1;
    for (int k = 2; k < T_STOP; k++) exp_busy[t0 + k] = 1'b1;
    exp_dlv[t0 + T_DLV] = int'(b);
    for (int i = 0; i < 10; i++) begin
      i_rx = fr[i];
      repeat (CPB) tick();
    end
  endtask

  int t0, ta, tb, base, fbase, obase;

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_dlv[i]  = -1;
      exp_ferr[i] = 1'b0;
      exp_busy[i] = 1'b0;
    end
    wb_rst_n = 1'b0;
    i_rx     = 1'b1;
    i_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    wb_rst_n = 1'b1;
    idle(20);

    // single byte, consumer always ready
    base = rise_t.size();
    send_frame(8'h55, t0);
    idle(10);
    chk("n_rise_55", 32'(rise_t.size() - base), 32'd1);
    if (rise_t.size() > base) begin
      chk("lat_55",  32'(rise_t[base]), 32'(t0 + 155));
      chk("data_55", 32'(rise_d[base]), 32'h55);
    end
    chk("ferr_55", 32'(ferr_cnt), 32'd0);
    chk("ovr_55",  32'(ovr_cnt),  32'd0);

    // three frames with no idle gap
    base = rise_t.size();
    send_frame(8'h48, t0);
    send_frame(8'h65, ta);
    send_frame(8'h6C, tb);
    idle(20);
    chk("n_rise_b2b", 32'(rise_t.size() - base), 32'd3);
    if (rise_t.size() >= base + 3) begin
      chk("gap_1",  32'(rise_t[base + 1] - rise_t[base]),     32'd160);
      chk("gap_2",  32'(rise_t[base + 2] - rise_t[base + 1]), 32'd160);
      chk("b2b_d0", 32'(rise_d[base]),     32'h48);
      chk("b2b_d1", 32'(rise_d[base + 1]), 32'h65);
      chk("b2b_d2", 32'(rise_d[base + 2]), 32'h6C);
    end

    // consumer stalled: second byte must be dropped with one overrun
    obase   = ovr_cnt;
    i_ready = 1'b0;
    send_frame(8'hA5, ta);
    send_frame(8'h3C, tb);
    idle(10);
    chk("held_valid", 32'(o_valid), 32'd1);
    chk("held_data",  32'(o_data),  32'hA5);
    chk("ovr_once",   32'(ovr_cnt - obase), 32'd1);
    i_ready = 1'b1;
    tick();
    chk("accept_clr", 32'(o_valid), 32'd0);
    idle(10);

    // break: 30 bit times low
    base  = rise_t.size();
    fbase = ferr_cnt;
    t0 = edge_n + 1;
    for (int k = 2; k <= 30 * CPB + 1; k++) exp_busy[t0 + k] = 1'b1;
    exp_ferr[t0 + T_STOP] = 1'b1;
    i_rx = 1'b0;
    repeat (30 * CPB) tick();
    idle(20);
    chk("break_ferr",  32'(ferr_cnt - fbase),      32'd1);
    chk("break_nodat", 32'(rise_t.size() - base),  32'd0);

    // short low glitch on an idle line
    base  = rise_t.size();
    fbase = ferr_cnt;
    obase = ovr_cnt;
    t0 = edge_n + 1;
    for (int k = 2; k <= HALF + 1; k++) exp_busy[t0 + k] = 1'b1;
    i_rx = 1'b0;
    repeat (4) tick();
    idle(20);
    chk("glitch_nodat", 32'(rise_t.size() - base), 32'd0);
    chk("glitch_ferr",  32'(ferr_cnt - fbase),     32'd0);
    chk("glitch_ovr",   32'(ovr_cnt - obase),      32'd0);

    // reset asserted in the middle of data bit 4
    base = rise_t.size();
    t0 = edge_n + 1;
    for (int k = 2; k <= 5 * CPB + HALF - 1; k++) exp_busy[t0 + k] = 1'b1;
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h96, 1'b0};
      for (int i = 0; i < 5; i++) begin
        i_rx = fr[i];
        repeat (CPB) tick();
      end
      i_rx = fr[5];
      repeat (HALF) tick();
    end
    wb_rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(o_valid),     32'd0);
    chk("mid_rst_data",  32'(o_data),      32'd0);
    chk("mid_rst_busy",  32'(o_busy),      32'd0);
    chk("mid_rst_ferr",  32'(o_frame_err), 32'd0);
    chk("mid_rst_ovr",   32'(o_overrun),   32'd0);
    wb_rst_n = 1'b1;
    idle(40);
    send_frame(8'hC3, t0);
    idle(20);
    chk("n_rise_c3", 32'(rise_t.size() - base), 32'd1);
    if (rise_t.size() > base) begin
      chk("lat_c3",  32'(rise_t[base]), 32'(t0 + 155));
      chk("data_c3", 32'(rise_d[base]), 32'hC3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
